// File: rtl/matmul_pkg.sv
// Shared constants and helpers for the sequential fixed-point matrix multiplier:
// FSM encoding, accumulator sizing, flat-vector indexing and saturation bounds.
package matmul_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;

    // Wide enough for N full-precision products plus a pre-scaled Out seed.
    function automatic int acc_width(input int w, input int n);
        return 2 * w + $clog2(n) + 1;
    endfunction

    function automatic int flat_idx(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/matmul_if.sv
// Load/start/done handshake and flat operand/result buses of the matrix multiplier.
interface matmul_if #(
    parameter int N = 3,
    parameter int W = 8
);
    logic               load;
    logic               start;
    logic               acc;
    logic [N*N*W-1:0]   a_flat;
    logic [N*N*W-1:0]   b_flat;
    logic [N*N*W-1:0]   out_flat;
    logic               busy;
    logic               done;

    modport master (
        output load, start, acc, a_flat, b_flat,
        input  out_flat, busy, done
    );

    modport slave (
        input  load, start, acc, a_flat, b_flat,
        output out_flat, busy, done
    );
endinterface

// File: rtl/fxp_mac.sv
// Signed multiply-accumulate with a seedable accumulator and a
// floor-shift-and-saturate output stage back to W bits.
module fxp_mac
    import matmul_pkg::*;
#(
    parameter int W    = 8,
    parameter int FRAC = 5,
    parameter int ACCW = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   first,
    input  logic signed [ACCW-1:0] init_val,
    input  logic signed [W-1:0]    a,
    input  logic signed [W-1:0]    b,
    output logic signed [W-1:0]    q
);
    localparam logic signed [ACCW-1:0] MAX_V = ACCW'(sat_max(W));
    localparam logic signed [ACCW-1:0] MIN_V = ACCW'(sat_min(W));

    logic signed [2*W-1:0]  prod;
    logic signed [ACCW-1:0] base;
    logic signed [ACCW-1:0] shifted;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] acc_q;

    always_comb begin
        prod    = a * b;
        base    = first ? init_val : acc_q;
        acc_d   = en ? base + ACCW'(prod) : acc_q;
        // Arithmetic shift floors toward minus infinity; no rounding term.
        shifted = acc_q >>> FRAC;
        if (shifted > MAX_V) begin
            q = MAX_V[W-1:0];
        end else if (shifted < MIN_V) begin
            q = MIN_V[W-1:0];
        end else begin
            q = shifted[W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matmul_seq.sv
// Sequential N x N signed fixed-point matrix multiplier (C = A*B or C = A*B + C)
// iterating one shared MAC over row-major elements, N MAC cycles plus one store each.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int N    = 3,
    parameter int W    = 8,
    parameter int FRAC = 5
) (
    input logic     clk,
    input logic     rst,
    matmul_if.slave bus
);
    localparam int             ACCW = acc_width(W, N);
    localparam int             IW   = $clog2(N);
    localparam int             FW   = N * N * W;
    localparam int             XW   = $clog2(FW);
    localparam logic [IW-1:0]  LAST = IW'(N - 1);

    logic [1:0]             state_q, state_d;
    logic [IW-1:0]          row_q, row_d;
    logic [IW-1:0]          col_q, col_d;
    logic [IW-1:0]          k_q, k_d;
    logic [FW-1:0]          a_q, a_d;
    logic [FW-1:0]          b_q, b_d;
    logic [FW-1:0]          out_q, out_d;
    logic                   acc_mode_q, acc_mode_d;
    logic                   done_q, done_d;

    logic [XW-1:0]          a_idx, b_idx, o_idx;
    logic signed [W-1:0]    a_el, b_el, o_el, mac_out;
    logic signed [ACCW-1:0] init_val;

    always_comb begin
        a_idx    = XW'(flat_idx(int'(row_q), int'(k_q), N, W));
        b_idx    = XW'(flat_idx(int'(k_q), int'(col_q), N, W));
        o_idx    = XW'(flat_idx(int'(row_q), int'(col_q), N, W));
        a_el     = a_q[a_idx +: W];
        b_el     = b_q[b_idx +: W];
        o_el     = out_q[o_idx +: W];
        // Accumulate mode seeds with the current Out element rescaled to product precision.
        init_val = acc_mode_q ? (ACCW'(o_el) <<< FRAC) : '0;
    end

    fxp_mac #(
        .W    (W),
        .FRAC (FRAC),
        .ACCW (ACCW)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == ST_MAC),
        .first    (k_q == '0),
        .init_val (init_val),
        .a        (a_el),
        .b        (b_el),
        .q        (mac_out)
    );

    // NOTE: every _d gets a default from its _q first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        k_d        = k_q;
        a_d        = a_q;
        b_d        = b_q;
        out_d      = out_q;
        acc_mode_d = acc_mode_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    a_d = bus.a_flat;
                    b_d = bus.b_flat;
                end
                if (bus.start) begin
                    state_d    = ST_MAC;
                    row_d      = '0;
                    col_d      = '0;
                    k_d        = '0;
                    acc_mode_d = bus.acc;
                end
            end
            ST_MAC: begin
                if (k_q == LAST) begin
                    k_d     = '0;
                    state_d = ST_STORE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_STORE: begin
                out_d[o_idx +: W] = mac_out;
                state_d           = ST_MAC;
                if (col_q == LAST) begin
                    col_d = '0;
                    if (row_q == LAST) begin
                        row_d   = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            k_q        <= '0;
            // NOTE: the Out and operand register arrays are reset because a reset must visibly clear Out_flat.
            a_q        <= '0;
            b_q        <= '0;
            out_q      <= '0;
            acc_mode_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            k_q        <= k_d;
            a_q        <= a_d;
            b_q        <= b_d;
            out_q      <= out_d;
            acc_mode_q <= acc_mode_d;
            done_q     <= done_d;
        end
    end

    assign bus.out_flat = out_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Scoreboard bench for matmul_seq: stimulus pushes model results, a monitor pops
// and compares them (data and Done latency) on every Done pulse.
module tb_matmul_seq;

    localparam int N    = 3;
    localparam int W    = 8;
    localparam int FRAC = 5;
    localparam int FW   = N * N * W;
    localparam int LAT  = N * N * (N + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_if #(.N(N), .W(W)) bus ();

    matmul_seq #(.N(N), .W(W), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [FW-1:0] m;
        int            t0;
    } exp_t;

    exp_t sb[$];
    int   mo[N][N];
    int   n_checks = 0;
    int   n_err    = 0;
    int   edge_cnt = 0;
    bit   mon_prev_done;
    exp_t mon_e;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int el(input logic [FW-1:0] v, input int r, input int c);
        logic signed [W-1:0] x;
        x = v[(r * N + c) * W +: W];
        return int'(x);
    endfunction

    function automatic longint floor_div(input longint s, input longint d);
        longint q;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: C[i][j] = clamp(floor((seed*2^FRAC + sum_k A[i][k]*B[k][j]) / 2^FRAC))
    function automatic logic [FW-1:0] model(input logic [FW-1:0] a, input logic [FW-1:0] b, input bit accm);
        logic [FW-1:0] r;
        longint        s;
        longint        one;
        r   = '0;
        one = 1;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = accm ? longint'(mo[i][j]) * (one << FRAC) : 0;
                for (int k = 0; k < N; k++) s += longint'(el(a, i, k)) * longint'(el(b, k, j));
                s = floor_div(s, one << FRAC);
                if (s > (one << (W - 1)) - 1) s = (one << (W - 1)) - 1;
                if (s < -(one << (W - 1))) s = -(one << (W - 1));
                r[(i * N + j) * W +: W] = W'(s);
            end
        end
        return r;
    endfunction

    task automatic push_exp(input logic [FW-1:0] a, input logic [FW-1:0] b, input bit accm, input int t0);
        exp_t e;
        e.m  = model(a, b, accm);
        e.t0 = t0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) mo[i][j] = el(e.m, i, j);
        sb.push_back(e);
    endtask

    function automatic logic [FW-1:0] fill(input logic [W-1:0] v);
        logic [FW-1:0] r;
        for (int i = 0; i < N * N; i++) r[i * W +: W] = v;
        return r;
    endfunction

    task automatic do_load(input logic [FW-1:0] a, input logic [FW-1:0] b);
        @(negedge clk);
        bus.a_flat = a;
        bus.b_flat = b;
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
    endtask

    task automatic do_start(input logic [FW-1:0] a, input logic [FW-1:0] b, input bit accm);
        @(negedge clk);
        bus.start = 1'b1;
        bus.acc   = accm;
        push_exp(a, b, accm, edge_cnt + 1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.acc   = 1'b0;
        check("busy_after_start", FW'(bus.busy), FW'(1'b1));
    endtask

    task automatic wait_done();
        int cnt = 0;
        while (!bus.done && cnt < 4 * LAT) begin
            @(negedge clk);
            cnt++;
        end
        if (!bus.done) begin
            n_checks++;
            n_err++;
            $display("FAIL done_timeout: got no Done within %0d cycles, required Done", 4 * LAT);
        end else begin
            check("busy_at_done", FW'(bus.busy), '0);
        end
    endtask

    task automatic run(input logic [FW-1:0] a, input logic [FW-1:0] b, input bit accm);
        do_load(a, b);
        do_start(a, b, accm);
        wait_done();
    endtask

    // Monitor: compares every Done against the oldest pending expectation.
    initial begin
        mon_prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev_done = 1'b0;
            end else begin
                if (mon_prev_done) check("done_pulse_width", FW'(bus.done), '0);
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_done: got Done with no run pending, required none");
                    end else begin
                        mon_e = sb.pop_front();
                        check("result", bus.out_flat, mon_e.m);
                        check("done_latency", FW'(edge_cnt - mon_e.t0), FW'(LAT));
                    end
                end
                mon_prev_done = bus.done;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] base_a, base_b, a, b;
        bit            accm;

        rst        = 1'b1;
        bus.load   = 1'b0;
        bus.start  = 1'b0;
        bus.acc    = 1'b0;
        bus.a_flat = '0;
        bus.b_flat = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) mo[i][j] = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", FW'(bus.busy), '0);
        check("reset_done", FW'(bus.done), '0);
        check("reset_out", bus.out_flat, '0);
        rst = 1'b0;

        // Base product
        base_a         = fill(8'h20);
        base_a[7:0]    = 8'h24;
        base_b         = fill(8'h28);
        run(base_a, base_b, 1'b0);
        check("base_row0", FW'(bus.out_flat[0 +: W]), FW'(8'h7D));
        check("base_row1", FW'(bus.out_flat[3 * W +: W]), FW'(8'h78));
        check("base_row2", FW'(bus.out_flat[8 * W +: W]), FW'(8'h78));

        // Accumulate onto the base result
        a = '0;
        for (int i = 0; i < N; i++) a[(i * N + i) * W +: W] = 8'h20;
        run(a, fill(8'h04), 1'b1);
        check("acc_row0_sat", FW'(bus.out_flat[1 * W +: W]), FW'(8'h7F));
        check("acc_row1", FW'(bus.out_flat[4 * W +: W]), FW'(8'h7C));

        // Saturation both ways
        run(fill(8'h7F), fill(8'h7F), 1'b0);
        check("sat_pos", bus.out_flat, fill(8'h7F));
        run(fill(8'hE0), fill(8'h7F), 1'b0);
        check("sat_neg", bus.out_flat, fill(8'h80));

        // Floor truncation
        a = '0; a[7:0] = 8'h01;
        run(a, a, 1'b0);
        check("trunc_pos", bus.out_flat, '0);
        a = '0; a[7:0] = 8'hFF;
        b = '0; b[7:0] = 8'h01;
        run(a, b, 1'b0);
        check("trunc_neg", bus.out_flat, FW'(8'hFF));

        // Load and Start at cycle 10 of a run are ignored
        do_load(base_a, base_b);
        do_start(base_a, base_b, 1'b0);
        repeat (9) @(negedge clk);
        bus.a_flat = fill(8'h7F);
        bus.b_flat = fill(8'h11);
        bus.load   = 1'b1;
        bus.start  = 1'b1;
        bus.acc    = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
        bus.start  = 1'b0;
        bus.acc    = 1'b0;
        wait_done();
        do_start(base_a, base_b, 1'b0);
        wait_done();

        // Start held across the Done edge restarts one edge later
        @(negedge clk);
        bus.start = 1'b1;
        bus.acc   = 1'b0;
        push_exp(base_a, base_b, 1'b0, edge_cnt + 1);
        @(negedge clk);
        wait_done();
        push_exp(base_a, base_b, 1'b0, edge_cnt + 1);
        @(negedge clk);
        check("restart_busy", FW'(bus.busy), FW'(1'b1));
        bus.start = 1'b0;
        wait_done();

        // Randomized runs
        repeat (4) begin
            for (int i = 0; i < N * N; i++) begin
                a[i * W +: W] = W'($urandom);
                b[i * W +: W] = W'($urandom);
            end
            accm = 1'($urandom_range(0, 1));
            run(a, b, accm);
        end

        // Reset in the middle of a run
        do_load(base_a, base_b);
        do_start(base_a, base_b, 1'b0);
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_busy", FW'(bus.busy), '0);
        check("midrun_done", FW'(bus.done), '0);
        check("midrun_out", bus.out_flat, '0);
        sb.delete();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) mo[i][j] = 0;
        @(negedge clk);
        rst = 1'b0;
        run(base_a, base_b, 1'b0);
        check("post_reset_row0", FW'(bus.out_flat[0 +: W]), FW'(8'h7D));

        repeat (3) @(negedge clk);
        check("scoreboard_empty", FW'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/matmul_seq.md
# matmul_seq

Parametrised sequential N×N signed fixed-point matrix multiplier: computes C = A·B, or C = A·B + C_prev in accumulate mode, with one shared multiply-accumulate datapath iterated over all (row, col, k). Successor to the fixed 3×3 8-bit matrix block. Sits behind a load/start/done handshake, so a controller can reload operands and chain products without re-wiring 27 ports.

## Interface
- N, default 3: matrix dimension (≥2).
- W, default 8: element width, signed two's complement.
- FRAC, default 5: fractional bits (Q(W-1-FRAC).FRAC; 0x20 = 1.0 at defaults).
- clk  in  1  rising-edge clock; the only clock.
- Reset  in  1  asynchronous, active-high reset.
- Load  in  1  capture A_flat/B_flat into operand registers (IDLE only).
- Start  in  1  begin computation (IDLE only).
- Acc  in  1  sampled with Start: 1 = add result to current Out contents.
- A_flat  in  N*N*W  element (r,c) at bits [(r*N+c)*W +: W].
- B_flat  in  N*N*W  same packing.
- Out_flat  out  N*N*W  registered result, same packing.
- Busy  out  1  computation in progress.
- Done  out  1  one-cycle pulse when the last element is written.

## Operation
- FSM states: IDLE, MAC, STORE. Reset → IDLE; Out_flat, operand registers, accumulator, indices = 0; Busy = 0; Done = 0.
- IDLE + Load: operand registers ← A_flat/B_flat.
- IDLE + Start: → MAC, row = col = k = 0, Busy = 1, Acc latched. Load and Start in the same cycle: operands captured, and the run uses the new operands.
- Load/Start while Busy: ignored; operands and the latched Acc are frozen for the run.
- MAC (N cycles per element): acc += A[row][k]·B[k][col], full-precision signed product (2W bits). The accumulator is 2W+clog2(N)+1 bits and never overflows internally.
- Accumulator init per element: 0 when Acc = 0. When Acc = 1, it is sign-extended Out[row][col] << FRAC.
- STORE (1 cycle): Out[row][col] ← sat_W(acc >>> FRAC). The shift is arithmetic (floor toward −∞, no rounding). Saturation clamps to [−2^(W−1), 2^(W−1)−1].
- Element order is row-major. After the last STORE: → IDLE, Busy = 0, Done = 1 for one cycle.
- Out elements not yet written keep their previous values during a run.
- Reset mid-run aborts immediately: all outputs return to reset values, with no partial Done.

## Timing
- Start sampled at edge 0; Busy = 1 after edge 0.
- Element e (row-major, 0-based) is visible on Out_flat after edge (e+1)·(N+1).
- Last element visible, Busy = 0 and Done = 1 after edge N²(N+1); this is edge 36 at N = 3. Done = 0 after the next edge.
- A Start held high at the Done edge is ignored. The earliest accepted restart is the following edge.
- Latency is data-independent. Throughput is one result matrix per N²(N+1)+1 cycles back-to-back.

## Structure
- Package matmul_pkg:
  - state encoding (IDLE/MAC/STORE);
  - helper functions for accumulator width (2W+clog2(N)+1);
  - flat-index helper (r*N+c)*W;
  - saturation-bound constants.
- Sub-module fxp_mac:
  - one signed multiply plus accumulate register;
  - init/clear input;
  - shift-and-saturate output stage, parametrised by W, FRAC, ACCW.
- The top level holds the FSM, index counters, operand registers and the Out register array.

## Test plan
- Base product (N=3, W=8, FRAC=5):
  - stimulus: A all 0x20 except A00 = 0x24; B all 0x28; Load; Start, Acc = 0;
  - required: row 0 = 0x7D, rows 1–2 = 0x78; Done pulses exactly at edge 36; Busy high over edges 0..35.
- Saturation:
  - stimulus: A = B = all 0x7F;
  - required: every Out = 0x7F.
  - stimulus: A all 0xE0, B all 0x7F;
  - required: every Out = 0x80.
- Truncation floor:
  - stimulus: A00 = B00 = 0x01, rest 0;
  - required: Out00 = 0x00.
  - stimulus: A00 = 0xFF, B00 = 0x01;
  - required: Out00 = 0xFF; all other elements 0x00.
- Accumulate:
  - stimulus: after the base result (row 0 = 0x7D, rows 1–2 = 0x78), Load A = identity (0x20 diagonal), B all 0x04; Start with Acc = 1;
  - required: row 0 = 0x7F (saturated), rows 1–2 = 0x7C.
- Handshake:
  - stimulus: Load with different operands and Start, both asserted at cycle 10 of a run;
  - required: both ignored, and the result matches the original operands.
  - stimulus: Start held high across the Done edge;
  - required: the restart begins one edge later.
- Reset mid-run:
  - stimulus: Reset at cycle 15;
  - required: Busy = Done = 0 and Out_flat = 0 asynchronously; re-Load/Start reproduces the base result with Done at edge 36.
